// File: rtl/io_pkg.sv
// Shared types, code-class constants and head-character classifier for io_char_buffer.
package io_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        WAIT  = 2'd2
    } io_state_t;

    typedef enum logic [2:0] {
        CLS_NOP   = 3'd0,
        CLS_DIGIT = 3'd1,
        CLS_SIGN  = 3'd2,
        CLS_CR    = 3'd3,
        CLS_TAB   = 3'd4,
        CLS_WAIT  = 3'd5,
        CLS_STOP  = 3'd6
    } io_class_t;

    localparam logic [4:0] C_SIGN      = 5'b00001;
    localparam logic [4:0] C_CR        = 5'b00010;
    localparam logic [4:0] C_TAB       = 5'b00011;
    localparam logic [4:0] C_WAIT      = 5'b00111;
    localparam logic [4:0] C_STOP      = 5'b00100;
    localparam logic [4:0] C_DIGIT_MSK = 5'b10000;
    // Bit 3 is a don't-care for every control class.
    localparam logic [4:0] C_CLASS_MSK = 5'b10111;

    function automatic io_class_t classify(input logic [4:0] h);
        io_class_t c;
        c = CLS_NOP;
        if ((h & C_DIGIT_MSK) != 5'd0)          c = CLS_DIGIT;
        else if ((h & C_CLASS_MSK) == C_SIGN)   c = CLS_SIGN;
        else if ((h & C_CLASS_MSK) == C_CR)     c = CLS_CR;
        else if ((h & C_CLASS_MSK) == C_TAB)    c = CLS_TAB;
        else if ((h & C_CLASS_MSK) == C_WAIT)   c = CLS_WAIT;
        else if ((h & C_CLASS_MSK) == C_STOP)   c = CLS_STOP;
        return c;
    endfunction

endpackage

// File: rtl/io_char_fifo.sv
// Character FIFO; the head slot is exposed combinationally and reads zero when empty.
module io_char_fifo #(
    parameter int unsigned CHAR_W = 5,
    parameter int unsigned DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clr,
    input  logic                     push,
    input  logic                     pop,
    input  logic [CHAR_W-1:0]        din,
    output logic [CHAR_W-1:0]        head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic [CHAR_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic              do_pop;
    logic              do_push;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop & ~empty;
    // A push into a full FIFO is accepted only when the head leaves in the same cycle.
    assign do_push = push & (~full | do_pop);
    assign head    = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push && !clr) mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (clr) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_push && !do_pop)      count <= count + CNT_W'(1);
            else if (do_pop && !do_push) count <= count - CNT_W'(1);
        end
    end

endmodule

// File: rtl/io_char_buffer.sv
// Merges input-device character channels into a FIFO, classifies the head (OB)
// and serialises digits LSB-first through the OA shift register.
module io_char_buffer #(
    parameter int unsigned CHAR_W  = 5,
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned NUM_SRC = 5,
    parameter int unsigned DIGIT_W = 4
) (
    input  logic                        CLOCK,
    input  logic                        rst_n,
    input  logic [NUM_SRC-1:0]          src_valid,
    input  logic [NUM_SRC*CHAR_W-1:0]   src_data,
    input  logic                        in_enable,
    output logic                        src_ready,
    input  logic                        bit_strobe,
    input  logic                        wait_release,
    input  logic                        ready_clr,
    output logic [CHAR_W-1:0]           ob,
    output logic                        ob_valid,
    output logic                        oa_bit,
    output logic                        oa_valid,
    output logic                        os,
    output logic                        word_end,
    output logic                        tab_flag,
    output logic                        stop_pulse,
    output logic                        hc,
    output logic [$clog2(DEPTH):0]      count,
    output logic                        overrun,
    output logic                        collision
);

    import io_pkg::*;

    localparam int unsigned BCNT_W = (DIGIT_W > 1) ? $clog2(DIGIT_W) : 1;

    io_state_t          state;
    io_state_t          state_nx;
    io_class_t          cls;
    logic [CHAR_W-1:0]  merged;
    logic               push_req;
    logic               multi_src;
    logic               full;
    logic               empty;
    logic               pop;
    logic               flush;
    logic               load_oa;
    logic               os_set;
    logic               os_clr;
    logic [DIGIT_W-1:0] oa;
    logic [BCNT_W-1:0]  bit_cnt;

    // OR-merge of all strobing channels.
    always_comb begin
        merged = '0;
        for (int k = 0; k < int'(NUM_SRC); k++) begin
            if (src_valid[k]) merged = merged | src_data[k*CHAR_W +: CHAR_W];
        end
    end

    assign push_req  = (|src_valid) & in_enable;
    assign multi_src = (src_valid & (src_valid - NUM_SRC'(1))) != '0;

    io_char_fifo #(
        .CHAR_W (CHAR_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk   (CLOCK),
        .rst_n (rst_n),
        .clr   (ready_clr | flush),
        .push  (push_req),
        .pop   (pop),
        .din   (merged),
        .head  (ob),
        .count (count),
        .full  (full),
        .empty (empty)
    );

    assign ob_valid  = ~empty;
    assign src_ready = in_enable & ~full;
    assign oa_bit    = oa[0];
    assign oa_valid  = (state == SHIFT);
    assign hc        = ob_valid | (state != IDLE);

    // Next-state, pop decision and head-class pulses.
    always_comb begin
        state_nx   = state;
        pop        = 1'b0;
        flush      = 1'b0;
        load_oa    = 1'b0;
        os_set     = 1'b0;
        os_clr     = 1'b0;
        word_end   = 1'b0;
        tab_flag   = 1'b0;
        stop_pulse = 1'b0;
        cls        = classify(ob[4:0]);
        unique case (state)
            IDLE: begin
                if (ob_valid && !ready_clr) begin
                    pop = 1'b1;
                    case (cls)
                        CLS_DIGIT: begin
                            load_oa  = 1'b1;
                            state_nx = SHIFT;
                        end
                        CLS_SIGN: os_set = 1'b1;
                        CLS_CR: begin
                            word_end = 1'b1;
                            os_clr   = 1'b1;
                        end
                        CLS_TAB: begin
                            word_end = 1'b1;
                            tab_flag = 1'b1;
                            os_clr   = 1'b1;
                        end
                        CLS_WAIT: state_nx = WAIT;
                        CLS_STOP: begin
                            stop_pulse = 1'b1;
                            os_clr     = 1'b1;
                            flush      = 1'b1;
                        end
                        default: ;
                    endcase
                end
            end
            SHIFT: begin
                if (bit_strobe && bit_cnt == BCNT_W'(DIGIT_W - 1)) state_nx = IDLE;
            end
            WAIT: begin
                if (wait_release) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge CLOCK or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            oa      <= '0;
            bit_cnt <= '0;
            os      <= 1'b0;
        end else if (ready_clr) begin
            state   <= IDLE;
            oa      <= '0;
            bit_cnt <= '0;
            os      <= 1'b0;
        end else begin
            state <= state_nx;
            if (load_oa) begin
                oa      <= ob[DIGIT_W-1:0];
                bit_cnt <= '0;
            end else if (state == SHIFT && bit_strobe) begin
                oa      <= oa >> 1;
                bit_cnt <= bit_cnt + BCNT_W'(1);
            end
            if (os_clr)      os <= 1'b0;
            else if (os_set) os <= 1'b1;
        end
    end

    // Sticky set/reset flags; clear wins over set.
    always_ff @(posedge CLOCK or negedge rst_n) begin
        if (!rst_n)                        overrun <= 1'b0;
        else if (ready_clr)                overrun <= 1'b0;
        else if (push_req && full && !pop) overrun <= 1'b1;
    end

    always_ff @(posedge CLOCK or negedge rst_n) begin
        if (!rst_n)         collision <= 1'b0;
        else if (ready_clr) collision <= 1'b0;
        else if (multi_src) collision <= 1'b1;
    end

endmodule

// File: tb/tb_io_char_buffer.sv
// Self-checking bench for io_char_buffer: directed scenarios with scoreboards
// for serial digit bits, word-end events and stop pulses.
module tb_io_char_buffer;

    localparam int unsigned CHAR_W  = 5;
    localparam int unsigned DEPTH   = 4;
    localparam int unsigned NUM_SRC = 5;
    localparam int unsigned DIGIT_W = 4;

    logic                       CLOCK = 1'b0;
    logic                       rst_n;
    logic [NUM_SRC-1:0]         src_valid;
    logic [NUM_SRC*CHAR_W-1:0]  src_data;
    logic                       in_enable;
    logic                       src_ready;
    logic                       bit_strobe;
    logic                       wait_release;
    logic                       ready_clr;
    logic [CHAR_W-1:0]          ob;
    logic                       ob_valid;
    logic                       oa_bit;
    logic                       oa_valid;
    logic                       os;
    logic                       word_end;
    logic                       tab_flag;
    logic                       stop_pulse;
    logic                       hc;
    logic [$clog2(DEPTH):0]     count;
    logic                       overrun;
    logic                       collision;

    int n_cmp = 0;
    int n_bad = 0;

    logic       bits_q [$];
    logic [1:0] we_q   [$];
    logic       stop_q [$];

    io_char_buffer #(
        .CHAR_W  (CHAR_W),
        .DEPTH   (DEPTH),
        .NUM_SRC (NUM_SRC),
        .DIGIT_W (DIGIT_W)
    ) dut (
        .CLOCK        (CLOCK),
        .rst_n        (rst_n),
        .src_valid    (src_valid),
        .src_data     (src_data),
        .in_enable    (in_enable),
        .src_ready    (src_ready),
        .bit_strobe   (bit_strobe),
        .wait_release (wait_release),
        .ready_clr    (ready_clr),
        .ob           (ob),
        .ob_valid     (ob_valid),
        .oa_bit       (oa_bit),
        .oa_valid     (oa_valid),
        .os           (os),
        .word_end     (word_end),
        .tab_flag     (tab_flag),
        .stop_pulse   (stop_pulse),
        .hc           (hc),
        .count        (count),
        .overrun      (overrun),
        .collision    (collision)
    );

    always #5 CLOCK = ~CLOCK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge CLOCK);
        #1;
    endtask

    task automatic push_ch(input int k, input logic [4:0] d);
        src_valid = NUM_SRC'(1) << k;
        src_data  = '0;
        src_data[k*CHAR_W +: CHAR_W] = d;
        tick();
        src_valid = '0;
        src_data  = '0;
    endtask

    task automatic expect_digit(input logic [4:0] d);
        for (int i = 0; i < int'(DIGIT_W); i++) bits_q.push_back(d[i]);
    endtask

    task automatic strobes(input int n);
        bit_strobe = 1'b1;
        repeat (n) tick();
        bit_strobe = 1'b0;
    endtask

    // Output-side scoreboards, sampled on the falling edge.
    always @(negedge CLOCK) begin
        if (rst_n) begin
            if (oa_valid && bit_strobe) begin
                check("bit_expected", 32'(bits_q.size() != 0), 1);
                if (bits_q.size() != 0) check("oa_bit", 32'(oa_bit), 32'(bits_q.pop_front()));
            end
            if (word_end) begin
                check("we_expected", 32'(we_q.size() != 0), 1);
                if (we_q.size() != 0) check("tab_os", 32'({tab_flag, os}), 32'(we_q.pop_front()));
            end
            if (stop_pulse) begin
                check("stop_expected", 32'(stop_q.size() != 0), 1);
                if (stop_q.size() != 0) check("stop_pulse", 32'(stop_pulse), 32'(stop_q.pop_front()));
            end
        end
    end

    initial begin
        #200000;
        n_bad++;
        $display("FAIL watchdog: got timeout expected finish");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        logic [4:0] drain [4];
        rst_n = 1'b0; src_valid = '0; src_data = '0; in_enable = 1'b1;
        bit_strobe = 1'b0; wait_release = 1'b0; ready_clr = 1'b0;
        drain[0] = 5'b00101; drain[1] = 5'b00110; drain[2] = 5'b01000; drain[3] = 5'b01110;

        repeat (2) @(posedge CLOCK);
        #1;
        check("rst_count", 32'(count), 0);
        check("rst_ob", 32'(ob), 0);
        check("rst_ob_valid", 32'(ob_valid), 0);
        check("rst_os", 32'(os), 0);
        check("rst_hc", 32'(hc), 0);
        check("rst_oa_valid", 32'(oa_valid), 0);
        check("rst_sticky", 32'({overrun, collision}), 0);
        rst_n = 1'b1;
        tick();

        // Single digit from channel 2.
        expect_digit(5'b10101);
        push_ch(2, 5'b10101);
        check("t1_ob", 32'(ob), 32'h15);
        check("t1_count1", 32'(count), 1);
        tick();
        check("t1_oa_valid_on", 32'(oa_valid), 1);
        check("t1_count0", 32'(count), 0);
        strobes(4);
        check("t1_oa_valid_off", 32'(oa_valid), 0);
        check("t1_count_end", 32'(count), 0);

        // Signed word ended by CR.
        push_ch(0, 5'b00001);
        expect_digit(5'b10011);
        push_ch(1, 5'b10011);
        expect_digit(5'b10001);
        push_ch(3, 5'b10001);
        we_q.push_back(2'b01);
        push_ch(4, 5'b00010);
        check("t2_os_d1", 32'(os), 1);
        check("t2_shift_d1", 32'(oa_valid), 1);
        strobes(4);
        tick();
        check("t2_os_d2", 32'(os), 1);
        check("t2_shift_d2", 32'(oa_valid), 1);
        strobes(4);
        check("t2_word_end", 32'(word_end), 1);
        check("t2_os_at_cr", 32'(os), 1);
        check("t2_tab_flag", 32'(tab_flag), 0);
        tick();
        check("t2_os_after", 32'(os), 0);
        check("t2_word_end_off", 32'(word_end), 0);

        // Signed word ended by TAB.
        push_ch(0, 5'b00001);
        we_q.push_back(2'b11);
        push_ch(0, 5'b00011);
        check("t2_tab_word_end", 32'(word_end), 1);
        check("t2_tab_flag1", 32'(tab_flag), 1);
        tick();
        check("t2_tab_os_after", 32'(os), 0);

        // Fill to full while shifting, then overflow.
        expect_digit(5'b10000);
        push_ch(1, 5'b10000);
        for (int i = 0; i < 4; i++) push_ch(i, drain[i]);
        check("t3_count_full", 32'(count), 4);
        check("t3_src_ready", 32'(src_ready), 0);
        check("t3_no_overrun", 32'(overrun), 0);
        push_ch(4, 5'b01101);
        check("t3_overrun", 32'(overrun), 1);
        check("t3_count_held", 32'(count), 4);
        strobes(4);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("t3_drain%0d", i), 32'(ob), 32'(drain[i]));
            tick();
        end
        check("t3_count_empty", 32'(count), 0);
        check("t3_ob_empty", 32'(ob), 0);

        // Collision: two channels OR-merged.
        ready_clr = 1'b1;
        tick();
        ready_clr = 1'b0;
        check("t4_overrun_clr", 32'(overrun), 0);
        src_valid = 5'b00101;
        src_data  = '0;
        src_data[0*CHAR_W +: CHAR_W] = 5'b10001;
        src_data[2*CHAR_W +: CHAR_W] = 5'b10010;
        expect_digit(5'b10011);
        tick();
        src_valid = '0;
        src_data  = '0;
        check("t4_merged", 32'(ob), 32'h13);
        check("t4_collision", 32'(collision), 1);
        tick();
        check("t4_shift", 32'(oa_valid), 1);
        strobes(4);
        ready_clr = 1'b1;
        tick();
        ready_clr = 1'b0;
        check("t4_collision_clr", 32'(collision), 0);
        check("t4_count_clr", 32'(count), 0);

        // WAIT holds the following digit at the head.
        push_ch(3, 5'b00111);
        expect_digit(5'b10110);
        push_ch(3, 5'b10110);
        repeat (10) tick();
        check("t5_count", 32'(count), 1);
        check("t5_head", 32'(ob), 32'h16);
        check("t5_no_shift", 32'(oa_valid), 0);
        check("t5_hc", 32'(hc), 1);
        wait_release = 1'b1;
        tick();
        wait_release = 1'b0;
        check("t5_rel_no_shift", 32'(oa_valid), 0);
        tick();
        check("t5_shift", 32'(oa_valid), 1);
        check("t5_count0", 32'(count), 0);
        strobes(4);

        // STOP flushes the queue behind it and clears the sign.
        push_ch(0, 5'b00001);
        expect_digit(5'b10001);
        push_ch(0, 5'b10001);
        push_ch(1, 5'b00100);
        push_ch(1, 5'b10010);
        push_ch(1, 5'b10011);
        push_ch(1, 5'b10100);
        check("t6_count", 32'(count), 4);
        check("t6_os", 32'(os), 1);
        stop_q.push_back(1'b1);
        strobes(4);
        check("t6_stop_pulse", 32'(stop_pulse), 1);
        check("t6_stop_head", 32'(ob), 32'h04);
        tick();
        check("t6_count_flush", 32'(count), 0);
        check("t6_stop_off", 32'(stop_pulse), 0);
        check("t6_os_clr", 32'(os), 0);
        check("t6_hc", 32'(hc), 0);
        check("t6_bits_left", 32'(bits_q.size()), 0);
        check("t6_we_left", 32'(we_q.size()), 0);
        check("t6_stop_left", 32'(stop_q.size()), 0);

        // Asynchronous reset in the middle of a shift.
        push_ch(2, 5'b00001);
        expect_digit(5'b11001);
        push_ch(2, 5'b11001);
        push_ch(2, 5'b10111);
        check("t7_shift", 32'(oa_valid), 1);
        check("t7_os", 32'(os), 1);
        check("t7_count", 32'(count), 1);
        strobes(2);
        bits_q.delete();
        #2 rst_n = 1'b0;
        #1;
        check("t7_rst_oa_valid", 32'(oa_valid), 0);
        check("t7_rst_os", 32'(os), 0);
        check("t7_rst_count", 32'(count), 0);
        check("t7_rst_ob_valid", 32'(ob_valid), 0);
        #2 rst_n = 1'b1;
        tick();
        check("t7_post_hc", 32'(hc), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
